// File: rtl/moving_average_n.sv
// Windowed moving average over the last 2^len_eff signed samples, with a
// run-time selectable power-of-two window, one-cycle latency and bypass mode.
package opo_package;
    parameter int word_width = 16;
endpackage

module moving_average_n #(
    parameter int WIDTH    = opo_package::word_width,
    parameter int MAX_LOG2 = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [$clog2(MAX_LOG2+1)-1:0]   log2_len,
    input  logic                            clear,
    input  logic [WIDTH-1:0]                sample_in,
    input  logic                            sample_in_valid,
    output logic [WIDTH-1:0]                sample_out,
    output logic                            sample_out_valid,
    output logic                            window_full
);

    localparam int LW    = $clog2(MAX_LOG2 + 1);
    localparam int DEPTH = 1 << MAX_LOG2;
    localparam int SW    = WIDTH + MAX_LOG2;
    localparam int CW    = MAX_LOG2 + 1;

    logic [WIDTH-1:0]        buf_q [DEPTH];
    logic [MAX_LOG2-1:0]     wr_ptr_q;
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_d;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic [LW-1:0]           len_q;
    logic                    len_armed_q;
    logic [WIDTH-1:0]        sample_out_q;
    logic [WIDTH-1:0]        sample_out_d;
    logic                    sample_out_valid_q;
    logic                    window_full_q;

    logic [LW-1:0]           len_eff;
    logic [CW-1:0]           win_len;
    logic [MAX_LOG2-1:0]     rd_ptr;
    logic [WIDTH-1:0]        old_sample;
    logic                    len_change;
    logic                    flush;
    logic                    accept;

    always_comb begin
        len_eff = log2_len;
        if (log2_len > LW'(MAX_LOG2)) begin
            len_eff = LW'(MAX_LOG2);
        end
    end

    // At full window the oldest entry is the one about to be overwritten,
    // which the modulo-depth subtraction yields naturally.
    assign win_len    = CW'(1) << len_eff;
    assign rd_ptr     = wr_ptr_q - win_len[MAX_LOG2-1:0];
    assign old_sample = buf_q[rd_ptr];

    // len_q only becomes meaningful after the first post-reset edge, so a
    // length differing from the reset value must not drop the first sample.
    assign len_change = len_armed_q && (len_eff != len_q);
    assign flush      = clear || len_change;
    assign accept     = sample_in_valid && !flush;

    always_comb begin
        sum_d = sum_q
              + {{MAX_LOG2{sample_in[WIDTH-1]}}, sample_in}
              - {{MAX_LOG2{old_sample[WIDTH-1]}}, old_sample};
    end

    always_comb begin
        count_d = count_q + CW'(1);
        if (count_q >= win_len) begin
            count_d = win_len;
        end
    end

    always_comb begin
        sample_out_d = sample_in;
        if (enable) begin
            sample_out_d = WIDTH'(sum_d >>> len_eff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q           <= '0;
            sum_q              <= '0;
            count_q            <= '0;
            len_q              <= '0;
            len_armed_q        <= 1'b0;
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
            window_full_q      <= 1'b0;
        end else begin
            len_q              <= len_eff;
            len_armed_q        <= 1'b1;
            sample_out_valid_q <= accept;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    buf_q[i] <= '0;
                end
                wr_ptr_q      <= '0;
                sum_q         <= '0;
                count_q       <= '0;
                window_full_q <= 1'b0;
            end else if (sample_in_valid) begin
                buf_q[wr_ptr_q] <= sample_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                sum_q           <= sum_d;
                count_q         <= count_d;
                window_full_q   <= (count_d == win_len);
                sample_out_q    <= sample_out_d;
            end
        end
    end

    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;
    assign window_full      = window_full_q;

endmodule

// File: tb/tb_moving_average_n.sv
// Directed bench for moving_average_n: a driver pushes hand-computed
// expectations (value, window_full, output cycle) and a monitor pops them.
module tb_moving_average_n;

  localparam int W  = 16;
  localparam int EW = 32 + 1 + W;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [2:0]   log2_len;
  logic         clear;
  logic [W-1:0] sample_in;
  logic         sample_in_valid;
  logic [W-1:0] sample_out;
  logic         sample_out_valid;
  logic         window_full;

  logic [EW-1:0] exp_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [2:0]    cur_len = 3'd1;
  logic          cur_en = 1'b1;
  logic          cur_rst = 1'b0;

  moving_average_n #(.WIDTH(W), .MAX_LOG2(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .log2_len         (log2_len),
    .clear            (clear),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .window_full      (window_full)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic step(input logic v, input int s, input logic clr,
                      input logic push, input int e, input logic f);
    logic [W-1:0] sv;
    logic [W-1:0] ev;
    int           ce;
    @(negedge clk);
    sv              = s[W-1:0];
    ev              = e[W-1:0];
    rst             = cur_rst;
    sample_in_valid = v;
    sample_in       = sv;
    clear           = clr;
    log2_len        = cur_len;
    enable          = cur_en;
    ce              = cyc + 1;
    if (push) exp_q.push_back({ce[31:0], f, ev});
  endtask

  task automatic smp(input int s, input int e, input logic f);
    step(1'b1, s, 1'b0, 1'b1, e, f);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic drop(input int s, input logic clr);
    step(1'b1, s, clr, 1'b0, 0, 1'b0);
  endtask

  task automatic clear_cycle();
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks += 3;
    if (sample_out !== '0) begin
      errors++;
      $display("FAIL %s sample_out: got %0h expected 0", tag, sample_out);
    end
    if (sample_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s sample_out_valid: got %b expected 0", tag, sample_out_valid);
    end
    if (window_full !== 1'b0) begin
      errors++;
      $display("FAIL %s window_full: got %b expected 0", tag, window_full);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst === 1'b1 && sample_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe: unexpected sample_out_valid at cycle %0d, out=%0d", cyc,
                 $signed(sample_out));
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (sample_out !== e[W-1:0]) begin
          errors++;
          $display("FAIL data: got %0d expected %0d at cycle %0d", $signed(sample_out),
                   $signed(e[W-1:0]), cyc);
        end
        if (window_full !== e[W]) begin
          errors++;
          $display("FAIL full: got %b expected %b at cycle %0d", window_full, e[W], cyc);
        end
        if (cyc != int'(e[EW-1:W+1])) begin
          errors++;
          $display("FAIL latency: strobe at cycle %0d expected cycle %0d", cyc,
                   int'(e[EW-1:W+1]));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b1; log2_len = 3'd1; clear = 1'b0;
    sample_in = '0; sample_in_valid = 1'b0;
    #1;
    check_zero_outputs("reset_initial");

    // first sample on the first edge after reset release
    cur_rst = 1'b1;
    smp(8, 4, 1'b0);
    smp(10, 9, 1'b1);
    idle();

    // asynchronous mid-stream reset
    @(negedge clk);
    sample_in_valid = 1'b1;
    sample_in = 16'd77;
    rst = 1'b0;
    cur_rst = 1'b0;
    #1;
    check_zero_outputs("reset_midstream");
    @(negedge clk);
    sample_in_valid = 1'b0;
    cur_rst = 1'b1;
    smp(8, 4, 1'b0);

    // len=1 basic averaging
    clear_cycle();
    smp(100, 50, 1'b0);
    smp(200, 150, 1'b1);
    smp(300, 250, 1'b1);

    // len=2 negatives, then len=1 negatives (floor rounding)
    cur_len = 3'd2;
    idle();
    smp(-4, -1, 1'b0);
    smp(-4, -2, 1'b0);
    smp(-4, -3, 1'b0);
    smp(-4, -4, 1'b1);
    cur_len = 3'd1;
    idle();
    smp(-1, -1, 1'b0);
    smp(-2, -2, 1'b1);

    // len=4 full-scale ramp, buffer wrap
    cur_len = 3'd4;
    idle();
    for (int k = 1; k <= 20; k++) begin
      int m;
      m = (k > 16) ? 16 : k;
      smp(32767, (m * 32767) >>> 4, (k >= 16));
    end

    // bypass keeps history
    cur_len = 3'd1;
    idle();
    cur_en = 1'b0;
    smp(32767, 32767, 1'b0);
    cur_en = 1'b1;
    smp(1, 16384, 1'b1);

    // length change and clear both drop a concurrent sample
    smp(10, 5, 1'b1);
    smp(20, 15, 1'b1);
    cur_len = 3'd2;
    drop(999, 1'b0);
    smp(4, 1, 1'b0);
    smp(8, 3, 1'b0);
    drop(555, 1'b1);
    smp(40, 10, 1'b0);

    // len=0 is a pass-through
    cur_len = 3'd0;
    idle();
    smp(7, 7, 1'b1);
    smp(-3, -3, 1'b1);

    // oversized length clamps to 16 without repeated flushing
    cur_len = 3'd7;
    idle();
    smp(16, 1, 1'b0);
    smp(16, 2, 1'b0);
    idle();
    smp(32, 4, 1'b0);

    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing: no strobe for expected %0d due at cycle %0d",
               $signed(e[W-1:0]), int'(e[EW-1:W+1]));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moving_average_n.md
MOVING_AVERAGE_N -- requirements
Module: moving_average_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default word_width (opo_package), giving the signed two's-complement sample width.
REQ-002 The block SHALL have parameter MAX_LOG2, default 4, setting the maximum window to 2^MAX_LOG2 samples and the history buffer depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: 1 outputs the average, 0 passes sample_in through.
REQ-006 The block SHALL have port log2_len, input, $clog2(MAX_LOG2+1) bits: window length = 2^log2_len samples.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous flush of history, sum and fill count.
REQ-008 The block SHALL have port sample_in, input, WIDTH bits: signed input sample.
REQ-009 The block SHALL have port sample_in_valid, input, 1 bit: sample_in is consumed this cycle.
REQ-010 The block SHALL have port sample_out, output, WIDTH bits: signed result.
REQ-011 The block SHALL have port sample_out_valid, output, 1 bit: one-cycle strobe for sample_out.
REQ-012 The block SHALL have port window_full, output, 1 bit: the current window holds 2^len_eff real samples.

Function
REQ-013 The effective length len_eff SHALL be min(log2_len, MAX_LOG2), registered as len_q every cycle.
REQ-014 The history SHALL be a circular buffer of 2^MAX_LOG2 WIDTH-bit entries with a MAX_LOG2-bit write pointer that wraps modulo depth.
REQ-015 The running sum SHALL be signed, WIDTH+MAX_LOG2 bits, with all operands sign-extended.
REQ-016 On a valid sample: sum <= sum + sample_in - buf[(wr_ptr - 2^len_eff) mod depth]; buf[wr_ptr] <= sample_in; wr_ptr increments.
REQ-017 Zeroed buffer entries SHALL stand in for missing history, so outputs before the window is full equal the partial sum divided by 2^len_eff.
REQ-018 Latency SHALL be exactly 1 cycle: sample_out_valid is high the cycle after each sample_in_valid and low otherwise.
REQ-019 sample_out SHALL be (new sum) >>> len_eff (arithmetic shift, truncation toward negative infinity), keeping the low WIDTH bits.
REQ-020 When enable=0, sample_out SHALL be the registered sample_in; history and sum still update.
REQ-021 len_eff=0 SHALL give sample_out equal to sample_in.
REQ-022 The fill counter SHALL increment per valid sample and saturate at 2^len_eff; window_full = (count == 2^len_eff), registered together with sample_out.
REQ-023 clear=1 SHALL zero buffer, sum, wr_ptr, fill count and window_full in one cycle; clear has priority over a simultaneous sample_in_valid, that sample is dropped, and sample_out_valid is 0 next cycle.
REQ-024 A change of log2_len (log2_len != len_q) SHALL act as clear in that cycle, with the same priority over sample_in_valid.
REQ-025 Toggling enable SHALL NOT flush history.
REQ-026 The sum SHALL never overflow for any input sequence, since WIDTH+MAX_LOG2 bits hold 2^MAX_LOG2 full-scale samples.

Reset
REQ-027 While rst=0, sample_out, sample_out_valid, window_full, sum, wr_ptr, fill count, len_q and every buffer entry SHALL be 0, asynchronously.
REQ-028 After rst rises, the block SHALL accept a sample on the first clock edge; reset mid-stream discards all history.

Verification
REQ-029 Reset check: assert rst=0 mid-stream -> all outputs 0 immediately; the first post-reset sample 8 with len=1 gives 4.
REQ-030 len=1, enable=1, samples 100,200,300 -> sample_out 50,150,250, each valid one cycle later; window_full from the 2nd output on.
REQ-031 len=2, four samples -4 -> outputs -1,-2,-3,-4; window_full only with the 4th; len=1 samples -1,-2 -> -1,-2.
REQ-032 len=4, 20 samples 32767 -> ramps to 32767 at the 16th and holds; no overflow; the buffer wraps at the 17th.
REQ-033 enable=0, sample 16'h7FFF -> 16'h7FFF; re-enable with len=1, next sample 1 -> 16384 (history retained).
REQ-034 Mid-stream log2_len change with sample_in_valid, and clear with sample_in_valid -> no output strobe that cycle; the next output uses only new samples.
